// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage issue/hazard bundle: decode and writeback inputs, stall/issue/flush outputs.
interface id_hazard_ctrl_if;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [6:0]  wb_opcode;
  logic        ex_redirect;
  logic        issue;
  logic        stall;
  logic        flush;
  logic [31:0] busy_mask;
  logic        sb_err;

  modport master (
    output id_valid, id_inst, wb_valid, wb_rd, wb_opcode, ex_redirect,
    input  issue, stall, flush, busy_mask, sb_err
  );

  modport slave (
    input  id_valid, id_inst, wb_valid, wb_rd, wb_opcode, ex_redirect,
    output issue, stall, flush, busy_mask, sb_err
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Decode issue controller: per-register pending-write scoreboard, RAW/structural stall,
// and a fixed-length decode flush window after an execute-stage redirect.
module id_hazard_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 2
) (
  input logic             clk,
  input logic             rst,
  id_hazard_ctrl_if.slave bus
);
  localparam int unsigned NREG = 32;
  localparam int unsigned FC_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             flush_q, flush_d;
  logic             sb_err_q, sb_err_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       use_rs1, use_rs2;
  logic       id_wr, wb_wr;
  logic       haz_rs1, haz_rs2, hazard, structural, idle;
  logic       issue_c;
  logic [NREG-1:0] inc_vec, dec_vec;
  logic       unused_inst;

  function automatic logic is_writer(logic [6:0] opc, logic [4:0] dst);
    return (dst != 5'd0) && (opc != OP_STORE) && (opc != OP_BRANCH);
  endfunction

  assign op          = bus.id_inst[6:0];
  assign rd          = bus.id_inst[11:7];
  assign rs1         = bus.id_inst[19:15];
  assign rs2         = bus.id_inst[24:20];
  assign unused_inst = ^{bus.id_inst[31:25], bus.id_inst[14:12]};

  // Which source fields the opcode actually reads
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (op)
      OP_OP, OP_OP32, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign id_wr = is_writer(op, rd);
  assign wb_wr = bus.wb_valid && is_writer(bus.wb_opcode, bus.wb_rd);

  // A last pending write retiring this cycle is forwarded by the register file
  assign haz_rs1 = use_rs1 && (rs1 != 5'd0) && (cnt_q[rs1] != '0) &&
                   !((cnt_q[rs1] == CNT_W'(1)) && wb_wr && (bus.wb_rd == rs1));
  assign haz_rs2 = use_rs2 && (rs2 != 5'd0) && (cnt_q[rs2] != '0) &&
                   !((cnt_q[rs2] == CNT_W'(1)) && wb_wr && (bus.wb_rd == rs2));

  assign hazard     = haz_rs1 || haz_rs2;
  assign structural = id_wr && (cnt_q[rd] == CNT_MAX);
  assign idle       = (state_q == IDLE);

  assign issue_c   = !rst && bus.id_valid && !hazard && !structural && !bus.ex_redirect && idle;
  assign bus.issue = issue_c;
  assign bus.stall = !rst && bus.id_valid && (hazard || structural) && idle && !bus.ex_redirect;
  assign bus.flush  = flush_q;
  assign bus.sb_err = sb_err_q;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      bus.busy_mask[i] = (cnt_q[i] != '0);
    end
  end

  assign inc_vec = (issue_c && id_wr) ? (NREG'(1) << rd) : '0;
  assign dec_vec = wb_wr ? (NREG'(1) << bus.wb_rd) : '0;

  // Scoreboard next state; matching inc/dec cancel, decrement of zero is flagged
  always_comb begin
    sb_err_d = sb_err_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) sb_err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Flush window FSM
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_redirect) begin
          state_d = FLUSH;
          fcnt_d  = FC_W'(FLUSH_CYC);
        end
      end
      FLUSH: begin
        if (bus.ex_redirect) begin
          fcnt_d = FC_W'(FLUSH_CYC);
        end else if (fcnt_q == FC_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
    flush_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fcnt_q   <= '0;
      flush_q  <= 1'b0;
      sb_err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      flush_q  <= flush_d;
      sb_err_q <= sb_err_d;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed scenarios plus random traffic against a counting model.
module tb_id_hazard_ctrl;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 2;
  localparam int CMAX      = (1 << CNT_W) - 1;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP32   = 7'b0111011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] IMM    = 7'b0010011;
  localparam logic [6:0] IMM32  = 7'b0011011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int mcnt [32];
  int mflush;
  bit merr;

  logic [6:0] optab [12] = '{OP, OP32, STORE, BRANCH, IMM, IMM32, LOAD, JALR, LUI, AUIPC, JAL, 7'b1110011};

  id_hazard_ctrl_if bus ();

  id_hazard_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit m_writer(logic [6:0] op, logic [4:0] rd);
    return (rd != 0) && (op != STORE) && (op != BRANCH);
  endfunction

  function automatic bit m_wbw();
    return bus.wb_valid && m_writer(bus.wb_opcode, bus.wb_rd);
  endfunction

  function automatic bit m_haz(int rs);
    if (rs == 0 || mcnt[rs] == 0) return 0;
    return !(mcnt[rs] == 1 && m_wbw() && int'(bus.wb_rd) == rs);
  endfunction

  function automatic bit m_blocked();
    logic [6:0] op = bus.id_inst[6:0];
    int rd  = int'(bus.id_inst[11:7]);
    int rs1 = int'(bus.id_inst[19:15]);
    int rs2 = int'(bus.id_inst[24:20]);
    bit u1 = op inside {OP, OP32, STORE, BRANCH, IMM, IMM32, LOAD, JALR};
    bit u2 = op inside {OP, OP32, STORE, BRANCH};
    bit h  = (u1 && m_haz(rs1)) || (u2 && m_haz(rs2));
    return h || (m_writer(op, bus.id_inst[11:7]) && mcnt[rd] == CMAX);
  endfunction

  function automatic bit m_issue();
    return !rst && bus.id_valid && mflush == 0 && !bus.ex_redirect && !m_blocked();
  endfunction

  function automatic bit m_stall();
    return !rst && bus.id_valid && mflush == 0 && !bus.ex_redirect && m_blocked();
  endfunction

  function automatic logic [35:0] m_expect();
    logic [31:0] b = '0;
    for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
    return {m_stall(), m_issue(), b, mflush != 0, merr};
  endfunction

  function automatic void m_update();
    bit iw, ww, same;
    int rd, wr;
    if (rst) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      mflush = 0;
      merr   = 0;
      return;
    end
    rd   = int'(bus.id_inst[11:7]);
    wr   = int'(bus.wb_rd);
    iw   = m_issue() && m_writer(bus.id_inst[6:0], bus.id_inst[11:7]);
    ww   = m_wbw();
    same = iw && ww && rd == wr;
    if (iw && !same) mcnt[rd]++;
    if (ww && !same) begin
      if (mcnt[wr] == 0) merr = 1;
      else mcnt[wr]--;
    end
    if (bus.ex_redirect) mflush = FLUSH_CYC;
    else if (mflush > 0) mflush--;
  endfunction

  // ---------------- drive helpers ----------------
  task automatic apply(input bit v, input logic [31:0] inst, input bit wv,
                       input logic [4:0] wrd, input logic [6:0] wop, input bit redir);
    @(negedge clk);
    bus.id_valid    = v;
    bus.id_inst     = inst;
    bus.wb_valid    = wv;
    bus.wb_rd       = wrd;
    bus.wb_opcode   = wop;
    bus.ex_redirect = redir;
    #1;
  endtask

  task automatic advance();
    m_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    apply(1, mk(IMM, 1, 0, 0), 1, 1, IMM, 1);
    checks++; if (bus.stall !== 1'b0 || bus.issue !== 1'b0) begin errors++;
      $display("FAIL reset_force got stall=%b issue=%b exp 0 0", bus.stall, bus.issue); end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
    checks++; if ({bus.flush, bus.busy_mask, bus.sb_err} !== 34'd0) begin errors++;
      $display("FAIL reset_vals got flush=%b busy=%h err=%b exp 0", bus.flush, bus.busy_mask, bus.sb_err); end
    advance();
  endtask

  task automatic test_back_to_back();
    apply(1, mk(OP, 5, 1, 2), 0, 0, 0, 0);
    checks++; if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL b2b_add got issue=%b stall=%b exp 1 0", bus.issue, bus.stall); end
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1, mk(OP, 6, 5, 3), 0, 0, 0, 0);
      checks++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0 || bus.busy_mask[5] !== 1'b1) begin errors++;
        $display("FAIL b2b_stall%0d got stall=%b issue=%b busy5=%b exp 1 0 1", k, bus.stall, bus.issue, bus.busy_mask[5]); end
      advance();
    end
    apply(1, mk(OP, 6, 5, 3), 1, 5, OP, 0);
    checks++; if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL b2b_bypass got issue=%b stall=%b exp 1 0", bus.issue, bus.stall); end
    advance();
    apply(0, 0, 1, 6, OP, 0);
    checks++; if (bus.busy_mask !== 32'h0000_0040) begin errors++;
      $display("FAIL b2b_busy got %h exp 00000040", bus.busy_mask); end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.busy_mask !== 32'h0 || bus.sb_err !== 1'b0) begin errors++;
      $display("FAIL b2b_drain got busy=%h err=%b exp 0 0", bus.busy_mask, bus.sb_err); end
    advance();
  endtask

  task automatic test_x0_store();
    apply(1, mk(IMM, 0, 0, 0), 0, 0, 0, 0);
    checks++; if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL x0_addi got issue=%b stall=%b exp 1 0", bus.issue, bus.stall); end
    advance();
    apply(1, mk(STORE, 0, 0, 0), 0, 0, 0, 0);
    checks++; if (bus.issue !== 1'b1 || bus.stall !== 1'b0 || bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL x0_sw got issue=%b stall=%b busy=%h exp 1 0 0", bus.issue, bus.stall, bus.busy_mask); end
    advance();
    apply(1, mk(IMM, 4, 0, 0), 0, 0, 0, 0);
    checks++; if (bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL x0_busy got %h exp 0", bus.busy_mask); end
    advance();
    apply(0, 0, 1, 4, STORE, 0);
    advance();
    apply(0, 0, 1, 4, BRANCH, 0);
    checks++; if (bus.busy_mask !== 32'h10) begin errors++;
      $display("FAIL store_wb got busy=%h exp 00000010", bus.busy_mask); end
    advance();
    apply(0, 0, 1, 4, IMM, 0);
    checks++; if (bus.busy_mask !== 32'h10 || bus.sb_err !== 1'b0) begin errors++;
      $display("FAIL branch_wb got busy=%h err=%b exp 00000010 0", bus.busy_mask, bus.sb_err); end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL x0_retire got busy=%h exp 0", bus.busy_mask); end
    advance();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      apply(1, mk(IMM, 7, 0, 0), 0, 0, 0, 0);
      checks++; if (bus.issue !== 1'b1) begin errors++;
        $display("FAIL sat_fill%0d got issue=%b exp 1", k, bus.issue); end
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      apply(1, mk(IMM, 7, 0, 0), 0, 0, 0, 0);
      checks++; if (bus.stall !== 1'b1 || bus.issue !== 1'b0) begin errors++;
        $display("FAIL sat_stall%0d got stall=%b issue=%b exp 1 0", k, bus.stall, bus.issue); end
      advance();
    end
    apply(1, mk(IMM, 7, 0, 0), 1, 7, IMM, 0);
    checks++; if (bus.stall !== 1'b1) begin errors++;
      $display("FAIL sat_wbcycle got stall=%b exp 1", bus.stall); end
    advance();
    apply(1, mk(IMM, 7, 0, 0), 0, 0, 0, 0);
    checks++; if (bus.issue !== 1'b1 || bus.stall !== 1'b0) begin errors++;
      $display("FAIL sat_issue got issue=%b stall=%b exp 1 0", bus.issue, bus.stall); end
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 1, 7, IMM, 0);
      checks++; if (bus.busy_mask !== 32'h80 || bus.sb_err !== 1'b0) begin errors++;
        $display("FAIL sat_drain%0d got busy=%h err=%b exp 00000080 0", k, bus.busy_mask, bus.sb_err); end
      advance();
    end
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL sat_empty got busy=%h exp 0", bus.busy_mask); end
    advance();
  endtask

  task automatic test_simultaneous();
    apply(1, mk(IMM, 9, 0, 0), 0, 0, 0, 0);
    advance();
    apply(1, mk(IMM, 9, 0, 0), 1, 9, IMM, 0);
    checks++; if (bus.issue !== 1'b1) begin errors++;
      $display("FAIL simul_issue got issue=%b exp 1", bus.issue); end
    advance();
    apply(0, 0, 1, 9, IMM, 0);
    checks++; if (bus.busy_mask !== 32'h200) begin errors++;
      $display("FAIL simul_busy got %h exp 00000200", bus.busy_mask); end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.busy_mask !== 32'h0 || bus.sb_err !== 1'b0) begin errors++;
      $display("FAIL simul_cnt1 got busy=%h err=%b exp 0 0", bus.busy_mask, bus.sb_err); end
    advance();
  endtask

  task automatic test_redirect();
    bit exp_fl [6] = '{1, 1, 1, 1, 0, 0};
    bit redir  [6] = '{0, 1, 0, 0, 0, 0};
    apply(1, mk(IMM, 10, 0, 0), 0, 0, 0, 0);
    advance();
    apply(1, mk(OP, 1, 2, 3), 0, 0, 0, 1);
    checks++; if (bus.issue !== 1'b0 || bus.stall !== 1'b0 || bus.flush !== 1'b0) begin errors++;
      $display("FAIL redir_cycle got issue=%b stall=%b flush=%b exp 0 0 0", bus.issue, bus.stall, bus.flush); end
    advance();
    apply(1, mk(OP, 1, 2, 3), 1, 10, IMM, 0);
    checks++; if (bus.flush !== 1'b1 || bus.issue !== 1'b0) begin errors++;
      $display("FAIL redir_fl1 got flush=%b issue=%b exp 1 0", bus.flush, bus.issue); end
    advance();
    apply(1, mk(OP, 1, 2, 3), 0, 0, 0, 0);
    checks++; if (bus.flush !== 1'b1 || bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL redir_fl2 got flush=%b busy=%h exp 1 0", bus.flush, bus.busy_mask); end
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.flush !== 1'b0) begin errors++;
      $display("FAIL redir_end got flush=%b exp 0", bus.flush); end
    advance();
    apply(0, 0, 0, 0, 0, 1);
    advance();
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 0, 0, 0, redir[k]);
      checks++; if (bus.flush !== exp_fl[k]) begin errors++;
        $display("FAIL redir_ext%0d got flush=%b exp %b", k, bus.flush, exp_fl[k]); end
      advance();
    end
  endtask

  task automatic test_reset_mid_flush();
    apply(1, mk(IMM, 5, 0, 0), 0, 0, 0, 0);
    advance();
    apply(0, 0, 0, 0, 0, 1);
    advance();
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.flush !== 1'b1 || bus.busy_mask !== 32'h20) begin errors++;
      $display("FAIL rmf_pre got flush=%b busy=%h exp 1 00000020", bus.flush, bus.busy_mask); end
    rst = 1'b1;
    advance();
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.flush !== 1'b0 || bus.busy_mask !== 32'h0 || bus.sb_err !== 1'b0) begin errors++;
      $display("FAIL rmf_clear got flush=%b busy=%h err=%b exp 0 0 0", bus.flush, bus.busy_mask, bus.sb_err); end
    advance();
    apply(0, 0, 1, 3, OP, 0);
    advance();
    for (int k = 0; k < 3; k++) begin
      apply(1, mk(IMM, 2, 0, 0), 0, 0, 0, 0);
      checks++; if (bus.sb_err !== 1'b1) begin errors++;
        $display("FAIL rmf_err%0d got err=%b exp 1", k, bus.sb_err); end
      advance();
    end
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0);
    checks++; if (bus.sb_err !== 1'b0 || bus.busy_mask !== 32'h0) begin errors++;
      $display("FAIL rmf_err_clr got err=%b busy=%h exp 0 0", bus.sb_err, bus.busy_mask); end
    advance();
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    logic [6:0]  op, wop;
    logic [4:0]  wrd;
    bit          v, wv, rdr;
    int          r;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 12);
      op  = (r == 12) ? 7'($urandom) : optab[r];
      wv  = 0; wrd = 0; wop = 0;
      if ($urandom_range(0, 2) == 0) begin
        r  = $urandom_range(1, 7);
        wv = 1;
        if (mcnt[r] > 0) begin
          wrd = 5'(r);
          wop = ($urandom_range(0, 1) != 0) ? IMM : LOAD;
        end else if ($urandom_range(0, 1) != 0) begin
          wrd = 5'(r);
          wop = ($urandom_range(0, 1) != 0) ? STORE : BRANCH;
        end else begin
          wrd = 0;
          wop = OP;
        end
      end
      rdr = ($urandom_range(0, 19) == 0);
      apply(v, mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
            wv, wrd, wop, rdr);
      exp = m_expect();
      got = {bus.stall, bus.issue, bus.busy_mask, bus.flush, bus.sb_err};
      checks++; if (got !== exp) begin errors++;
        $display("FAIL random cyc %0d got {stall,issue,busy,flush,err}=%h exp %h", c, got, exp); end
      advance();
    end
  endtask

  initial begin
    bus.id_valid = 0; bus.id_inst = 0; bus.wb_valid = 0;
    bus.wb_rd = 0; bus.wb_opcode = 0; bus.ex_redirect = 0;
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    mflush = 0;
    merr   = 0;
    test_reset();
    test_back_to_back();
    test_x0_store();
    test_saturation();
    test_simultaneous();
    test_redirect();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
